// File: rtl/fetch_stage.sv
// Program counter and IF/ID pipeline register for the RV32I core: stall, redirect and flush.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ADDR_W    = 11,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic              if_id_valid,
    output logic [31:0]       if_id_pc,
    output logic [31:0]       if_id_pc_plus4,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       fetch_count,
    output logic              fetch_fault,
    output logic              state_dbg
);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc;
    logic [31:0]  target_eff;

    // Redirect beats stall; a redirect squashes the word fetched this cycle (one bubble).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (state_q == RUN && redirect_valid && redirect_target[1:0] != 2'b00) begin
            state_d = FAULT;
        end
`endif
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_eff  = redirect_target;
    assign fetch_fault = (state_q == FAULT);
`else
    // Without the trap a misaligned target is silently word-aligned.
    assign target_eff  = {redirect_target[31:2], 2'b00};
    assign fetch_fault = 1'b0;
    logic unused_target_bits;
    assign unused_target_bits = ^redirect_target[1:0];
`endif

    assign state_dbg = state_q;
    assign imem_addr = pc[ADDR_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_id_valid    <= 1'b0;
            if_id_pc       <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
            if_id_instr    <= NOP_INSTR;
            fetch_count    <= 32'h0;
        end else if (state_q == FAULT) begin
            if_id_valid <= 1'b0;
        end else if (redirect_valid) begin
            pc          <= target_eff;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
        end else if (!stall) begin
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pc + 32'd4;
            if_id_instr    <= imem_data;
            if_id_valid    <= 1'b1;
            pc             <= pc + 32'd4;
            fetch_count    <= fetch_count + 32'd1;
        end
    end

endmodule
